// File: rtl/scaler_line_scheduler_if.sv
// Handshake bundle between the line-buffer writer, the vertical scaler read side
// and the line scheduler that arbitrates the four-bank ring between them.
interface scaler_line_scheduler_if;
    logic       frame_start;
    logic       wr_line_done;
    logic       wr_allow;
    logic [1:0] wr_bank;
    logic       rd_line_req;
    logic       rd_line_ack;
    logic [1:0] rd_bank;
    logic [9:0] rd_src_row;
    logic       rd_line_done;
    logic       frame_done;
    logic       overflow;

    modport slave (
        input  frame_start, wr_line_done, rd_line_req, rd_line_done,
        output wr_allow, wr_bank, rd_line_ack, rd_bank, rd_src_row, frame_done, overflow
    );

    modport master (
        output frame_start, wr_line_done, rd_line_req, rd_line_done,
        input  wr_allow, wr_bank, rd_line_ack, rd_bank, rd_src_row, frame_done, overflow
    );
endinterface

// File: rtl/scaler_line_scheduler.sv
// Vertical scaler line scheduler: tracks source lines held in a 4-bank ring and
// grants output lines one at a time, each mapped to its nearest source row.
module scaler_line_scheduler #(
    parameter int SRC_H       = 480,
    parameter int DST_H       = 720,
    parameter int Y_RATIO     = 43690,
    parameter int PRIME_LINES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    scaler_line_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    state_t      state;
    state_t      state_next;
    logic [9:0]  lines_written;
    logic [9:0]  dst_cnt;
    logic [26:0] y_acc;
    logic        rd_active;
    logic        ack;
    logic [9:0]  src_row;
    logic        overflow;

    logic [9:0]  next_row;
    logic [9:0]  low_row;
    logic [9:0]  fill_level;
    logic        writing;
    logic        wr_allow;
    logic        rd_done_ok;
    logic        grant;
    logic        frame_end;

    // Integer part of the accumulator rounded half-up, clamped to the last source row.
    function automatic logic [9:0] round_row(input logic [11:0] acc_hi);
        logic [11:0] r;
        r = {1'b0, acc_hi[11:1]} + {11'd0, acc_hi[0]};
        if (r > 12'(SRC_H - 1))
            return 10'(SRC_H - 1);
        return r[9:0];
    endfunction

    assign next_row   = round_row(y_acc[26:15]);
    assign low_row    = rd_active ? src_row : next_row;
    assign fill_level = lines_written - low_row;
    assign writing    = (state == FILL) || (state == RUN);
    assign wr_allow   = writing && (lines_written < 10'(SRC_H)) && (fill_level < 10'd4);
    assign rd_done_ok = bus.rd_line_done && rd_active;
    assign grant      = (state == RUN) && bus.rd_line_req && !rd_active
                        && (next_row < lines_written) && !ack;

    always_comb begin
        state_next = state;
        frame_end  = 1'b0;
        if (bus.frame_start) begin
            state_next = FILL;
        end else begin
            unique case (state)
                IDLE:  state_next = IDLE;
                FILL:  if (lines_written >= 10'(PRIME_LINES)) state_next = RUN;
                RUN:   if (grant && (dst_cnt == 10'(DST_H - 1))) state_next = DRAIN;
                DRAIN: if (rd_done_ok) begin
                           state_next = IDLE;
                           frame_end  = !rst;
                       end
                default: state_next = IDLE;
            endcase
        end
    end

    // Abort via frame_start wins over same-cycle writer/reader events; overflow survives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            lines_written <= '0;
            dst_cnt       <= '0;
            y_acc         <= '0;
            rd_active     <= 1'b0;
            ack           <= 1'b0;
            src_row       <= '0;
            overflow      <= 1'b0;
        end else begin
            state <= state_next;
            if (bus.frame_start) begin
                lines_written <= '0;
                dst_cnt       <= '0;
                y_acc         <= '0;
                rd_active     <= 1'b0;
                ack           <= 1'b0;
            end else begin
                ack <= grant;
                if (writing && bus.wr_line_done) begin
                    if (wr_allow)
                        lines_written <= lines_written + 10'd1;
                    else
                        overflow <= 1'b1;
                end
                if (grant) begin
                    dst_cnt   <= dst_cnt + 10'd1;
                    y_acc     <= y_acc + 27'(Y_RATIO);
                    src_row   <= next_row;
                    rd_active <= 1'b1;
                end else if (rd_done_ok) begin
                    rd_active <= 1'b0;
                end
            end
        end
    end

    assign bus.wr_allow    = wr_allow;
    assign bus.wr_bank     = lines_written[1:0];
    assign bus.rd_line_ack = ack;
    assign bus.rd_bank     = src_row[1:0];
    assign bus.rd_src_row  = src_row;
    assign bus.frame_done  = frame_end;
    assign bus.overflow    = overflow;

endmodule

// File: tb/tb_scaler_line_scheduler.sv
// Directed plus randomized bench for scaler_line_scheduler, checked against a
// frame-level model (row = round(k * ratio), ring occupancy, grant legality).
module tb_scaler_line_scheduler;
    localparam int SRC_H       = 480;
    localparam int DST_H       = 720;
    localparam int Y_RATIO     = 43690;
    localparam int PRIME_LINES = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scaler_line_scheduler_if bus();

    scaler_line_scheduler #(
        .SRC_H(SRC_H), .DST_H(DST_H), .Y_RATIO(Y_RATIO), .PRIME_LINES(PRIME_LINES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: m_frame 0 = no frame, 1 = filling/running, 2 = all lines granted
    int m_frame, m_lw, m_dst, m_row, m_acks;
    bit m_active, m_ovf;
    bit obs_ack;
    int last_row, rd_wait, fd_obs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_row(input int k);
        longint v;
        v = (longint'(k) * Y_RATIO + 32768) >>> 16;
        if (v > SRC_H - 1) v = SRC_H - 1;
        return int'(v);
    endfunction

    function automatic bit model_allow();
        int low;
        low = m_active ? m_row : exp_row(m_dst);
        return (m_frame == 1) && (m_lw < SRC_H) && (((m_lw - low) & 1023) < 4);
    endfunction

    task automatic model_reset();
        m_frame = 0; m_lw = 0; m_dst = 0; m_row = 0; m_acks = 0;
        m_active = 0; m_ovf = 0; rd_wait = 0;
    endtask

    task automatic step(input bit fs, input bit wr, input bit rdone, input bit req);
        bit allow, fd_exp, legal;
        @(negedge clk);
        bus.frame_start  = fs;
        bus.wr_line_done = wr;
        bus.rd_line_done = rdone;
        bus.rd_line_req  = req;
        #1;
        allow  = model_allow();
        fd_exp = !fs && (m_frame == 2) && rdone && m_active;
        chk("wr_allow", bus.wr_allow, allow);
        chk("wr_bank", bus.wr_bank, m_lw & 3);
        chk("frame_done", bus.frame_done, fd_exp);
        if (bus.frame_done) fd_obs++;
        @(posedge clk);
        #1;
        obs_ack = bus.rd_line_ack;
        if (obs_ack) begin
            legal = !fs && (m_frame == 1) && !m_active && (m_lw >= PRIME_LINES)
                    && (exp_row(m_dst) < m_lw);
            chk("ack_legal", obs_ack, legal);
            last_row = bus.rd_src_row;
        end
        if (fs) begin
            m_frame = 1; m_lw = 0; m_dst = 0; m_active = 0;
        end else begin
            if (wr && m_frame == 1) begin
                if (allow) m_lw++;
                else m_ovf = 1;
            end
            if (rdone && m_active) begin
                m_active = 0;
                if (m_frame == 2) m_frame = 0;
            end
            if (obs_ack) begin
                m_active = 1;
                m_row    = exp_row(m_dst);
                m_dst++;
                m_acks++;
                if (m_dst == DST_H) m_frame = 2;
                rd_wait = $urandom_range(0, 3);
            end
        end
        chk("overflow", bus.overflow, m_ovf);
        chk("rd_src_row", bus.rd_src_row, m_row);
        chk("rd_bank", bus.rd_bank, m_row & 3);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            bus.frame_start  = 1'($urandom);
            bus.wr_line_done = 1'($urandom);
            bus.rd_line_req  = 1'($urandom);
            bus.rd_line_done = 1'($urandom);
            @(posedge clk);
        end
        #1;
        chk({tag, "_wr_allow"}, bus.wr_allow, 0);
        chk({tag, "_wr_bank"}, bus.wr_bank, 0);
        chk({tag, "_ack"}, bus.rd_line_ack, 0);
        chk({tag, "_frame_done"}, bus.frame_done, 0);
        chk({tag, "_overflow"}, bus.overflow, 0);
        chk({tag, "_rd_bank"}, bus.rd_bank, 0);
        chk({tag, "_rd_src_row"}, bus.rd_src_row, 0);
        chk({tag, "_lines_written"}, dut.lines_written, 0);
        chk({tag, "_dst_cnt"}, dut.dst_cnt, 0);
        chk({tag, "_y_acc"}, dut.y_acc, 0);
        chk({tag, "_rd_active"}, dut.rd_active, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.frame_start = 0; bus.wr_line_done = 0; bus.rd_line_req = 0; bus.rd_line_done = 0;
        model_reset();
    endtask

    task automatic prime_check(input bit with_fs, input string tag);
        if (with_fs) step(1, 0, 0, 0);
        step(0, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            chk({tag, "_one_line_no_ack"}, obs_ack, 0);
        end
        step(0, 1, 0, 1);
        chk({tag, "_wr_edge_no_ack"}, obs_ack, 0);
        step(0, 0, 0, 1);
        chk({tag, "_ack_not_early"}, obs_ack, 0);
        step(0, 0, 0, 1);
        chk({tag, "_ack"}, obs_ack, 1);
        chk({tag, "_bank"}, bus.rd_bank, 0);
        chk({tag, "_row"}, bus.rd_src_row, 0);
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        do begin
            step(0, 0, 0, 1);
            n++;
        end while (!obs_ack && n < 20);
        chk({tag, "_ack"}, obs_ack, 1);
    endtask

    task automatic run_random(input bit stop_at_dst, input int dst_target,
                              input int max_cycles, input string tag);
        int n;
        bit wr, rdone;
        n = 0;
        while (n < max_cycles && m_frame != 0 && !(stop_at_dst && m_dst >= dst_target)) begin
            wr    = model_allow() && ($urandom_range(0, 2) != 0);
            rdone = 0;
            if (m_active) begin
                if (rd_wait == 0) rdone = 1;
                else rd_wait--;
            end
            step(0, wr, rdone, 1);
            n++;
        end
        chk({tag, "_in_time"}, (n < max_cycles), 1);
    endtask

    int rows[4];
    int exp_rows[4] = '{0, 1, 1, 2};

    initial begin
        bus.frame_start = 0; bus.wr_line_done = 0; bus.rd_line_req = 0; bus.rd_line_done = 0;
        model_reset();
        last_row = 0;
        fd_obs   = 0;

        do_reset("reset");

        // Frame A: priming, then nearest-row rounding sequence
        prime_check(1, "prime");
        rows[0] = last_row;
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        chk("round_lines_written", dut.lines_written, 4);
        for (int k = 1; k < 4; k++) begin
            step(0, 0, 1, 1);
            wait_ack("round");
            rows[k] = last_row;
        end
        for (int k = 0; k < 4; k++) chk("round_row", rows[k], exp_rows[k]);

        // Frame A continues to 100 grants, then is aborted
        run_random(1, 100, 4000, "pre_abort");
        chk("pre_abort_dst", dut.dst_cnt, 100);
        step(1, 0, 0, 0);
        chk("abort_lines_written", dut.lines_written, 0);
        chk("abort_dst_cnt", dut.dst_cnt, 0);
        chk("abort_y_acc", dut.y_acc, 0);
        chk("abort_rd_active", dut.rd_active, 0);
        chk("abort_wr_allow", bus.wr_allow, 1);
        chk("abort_frame_done_count", fd_obs, 0);
        prime_check(0, "abort_prime");

        // Frame C: ring backpressure and overflow
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        chk("bp_wr_allow_full", bus.wr_allow, 0);
        chk("bp_lines_written", dut.lines_written, 4);
        step(0, 1, 0, 0);
        chk("bp_overflow", bus.overflow, 1);
        chk("bp_lines_kept", dut.lines_written, 4);
        wait_ack("bp");
        chk("bp_row", bus.rd_src_row, 0);
        chk("bp_still_full", bus.wr_allow, 0);
        step(0, 0, 1, 0);
        chk("bp_low_row", dut.low_row, 1);
        chk("bp_wr_allow_free", bus.wr_allow, 1);

        // Mid-frame reset clears the sticky flag
        do_reset("mid_reset");

        // Full frame with random writer pacing and reader latency
        fd_obs = 0;
        step(1, 0, 0, 0);
        m_acks = 0;
        run_random(0, 0, 20000, "full");
        chk("full_acks", m_acks, DST_H);
        chk("full_last_row", last_row, SRC_H - 1);
        chk("full_frame_done_count", fd_obs, 1);
        chk("full_overflow", bus.overflow, 0);
        chk("full_lines_written", dut.lines_written, SRC_H);

        // Idle: writer and reader strobes are ignored
        step(0, 1, 1, 1);
        step(0, 0, 0, 1);
        chk("idle_no_ack", obs_ack, 0);
        chk("idle_overflow", bus.overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scaler_line_scheduler.md
SCALER_LINE_SCHEDULER -- requirements
Module: scaler_line_scheduler

Interface
REQ-001 SHALL have parameters: SRC_H, default 480, number of source lines per frame.
REQ-002 SHALL have parameter DST_H, default 720, number of output lines per frame.
REQ-003 SHALL have parameter Y_RATIO, default 43690, vertical step in unsigned 16.16 fixed point.
REQ-004 SHALL have parameter PRIME_LINES, default 2, source lines written before the first grant.
REQ-005 SHALL be single-clock with a synchronous, active-high reset. Ports, with widths in bits:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- frame_start  in  1  single-cycle pulse at the start of a source frame.
- wr_line_done  in  1  pulse: writer finished one source line into bank wr_bank.
- wr_allow  out  1  writer may fill bank wr_bank.
- wr_bank  out  2  bank for the next source line, equal to lines_written[1:0].
- rd_line_req  in  1  level: output side wants its next line, held until rd_line_ack.
- rd_line_ack  out  1  single-cycle grant.
- rd_bank  out  2  bank of the granted source row, valid from the ack until the next ack.
- rd_src_row  out  10  granted source row, same validity as rd_bank.
- rd_line_done  in  1  pulse: granted output line fully read.
- frame_done  out  1  single-cycle pulse at the end of the output frame.
- overflow  out  1  sticky error flag.

Function
REQ-006 SHALL manage 4 line banks as a ring; source row r SHALL reside in bank r[1:0].
REQ-007 SHALL keep the following counters:
- lines_written (10 bit): source lines completed.
- dst_cnt (10 bit): output lines granted.
- y_acc (27 bit, 16.16 format).
- rd_active flag: set on ack, cleared on rd_line_done.
REQ-008 Next source row SHALL be y_acc[26:16] + y_acc[15] (round to nearest), clamped to SRC_H-1.
REQ-009 SHALL add Y_RATIO to y_acc in the cycle rd_line_ack is asserted.
REQ-010 low_row SHALL be rd_src_row while rd_active=1, otherwise the next source row.
REQ-011 wr_allow SHALL be combinational, equal to 1 only when all of the following hold:
- state is FILL or RUN;
- lines_written < SRC_H;
- (lines_written - low_row) < 4.
REQ-012 On wr_line_done with wr_allow=1, lines_written SHALL increment by 1.
REQ-013 On wr_line_done with wr_allow=0, overflow SHALL be set to 1 and lines_written SHALL be left unchanged.
REQ-014 States: IDLE, FILL, RUN, DRAIN.
REQ-015 IDLE -> FILL on frame_start.
REQ-016 FILL -> RUN when lines_written >= PRIME_LINES.
REQ-017 RUN -> DRAIN on the ack that makes dst_cnt = DST_H.
REQ-018 DRAIN -> IDLE on rd_line_done; frame_done SHALL pulse in that same transition cycle.
REQ-019 frame_start in any state other than IDLE SHALL abort the frame in the next cycle:
- lines_written, dst_cnt, y_acc and rd_active cleared;
- state set to FILL;
- no frame_done pulse;
- overflow kept.
REQ-020 rd_line_ack SHALL be registered and SHALL assert one cycle after a cycle in which all of the following hold:
- state is RUN;
- rd_line_req=1;
- rd_active=0;
- next source row < lines_written;
- rd_line_ack=0.
REQ-021 rd_bank and rd_src_row SHALL update in the same cycle as the ack.
REQ-022 Consecutive acks SHALL be separated by a rd_line_done; maximum one line in flight.
REQ-023 rd_line_done with rd_active=0 SHALL be ignored.
REQ-024 wr_line_done and rd_line_done in the same cycle SHALL both be processed.
REQ-025 wr_allow SHALL be evaluated on pre-update values.
REQ-026 wr_line_done and wr_allow SHALL be ignored in IDLE and DRAIN; wr_line_done in those states SHALL NOT set overflow.

Reset
REQ-027 While rst=1, the block SHALL be forced to:
- state IDLE;
- all counters 0 and rd_active=0;
- wr_allow, rd_line_ack, frame_done, overflow = 0;
- rd_bank = 0, rd_src_row = 0.
REQ-028 Reset asserted mid-frame SHALL take priority over every other input in that cycle.
REQ-029 overflow SHALL clear only on reset.

Verification
REQ-030 Reset: hold rst 2 cycles with random inputs -> state IDLE, all outputs 0.
REQ-031 Prime (defaults), steps in order:
- frame_start, one wr_line_done, rd_line_req held -> no ack;
- second wr_line_done -> ack 2 cycles later, rd_bank=0, rd_src_row=0.
REQ-032 Rounding: after the prime, grant 4 lines with rd_line_done between them -> rd_src_row sequence 0, 1, 1, 2.
REQ-033 Backpressure, steps in order:
- no reads, write 4 lines -> wr_allow=0 after the 4th;
- extra wr_line_done -> overflow=1, lines_written stays 4;
- one grant of row 0 then its rd_line_done -> low_row 1, wr_allow=1.
REQ-034 Full frame: writer writes 480 lines when allowed, reader requests continuously -> 720 acks; last rd_src_row=479 (clamp not exceeded); exactly one frame_done; overflow=0.
REQ-035 Abort: frame_start after 100 acks -> next cycle state FILL, counters 0, no frame_done; following frame behaves as in REQ-031.
